// File: rtl/multicycle_adder.sv
// Multicycle adder/subtractor: adds CHUNK bits per cycle, LSB slice first.
// Ports: clk, rst_n (sync, active-low), start/sub/a/b/cin in; busy, done, sum, cout, ovf out.
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK:0]   slice;
   logic             c_msb;
   logic [WIDTH-1:0] acc_nxt;

   always_comb begin
      slice = {1'b0, a_q[CHUNK-1:0]}
            + {1'b0, b_q[CHUNK-1:0]}
            + (CHUNK+1)'(c_q);
      // carry into the top bit of this slice, recovered from the sum bit
      c_msb = slice[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
      // operands shift right, result slices enter from the top
      acc_nxt = (acc_q >> CHUNK)
              | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_RUN: begin
            a_d   = a_q >> CHUNK;
            b_d   = b_q >> CHUNK;
            c_d   = slice[CHUNK];
            acc_d = acc_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               sum_d   = acc_nxt;
               cout_d  = slice[CHUNK];
               ovf_d   = c_msb ^ slice[CHUNK];
            end
         end
         default: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               c_d     = sub | cin;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed testbench for multicycle_adder: 16/4, 8/1 and 8/8 instances.
// Ports: none; drives all DUT ports and prints one summary line.
module tb_multicycle_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // 16-bit, 4-bit chunks
   logic        start0 = 0, sub0 = 0, cin0 = 0;
   logic [15:0] a0 = 0, b0 = 0;
   logic        busy0, done0, cout0, ovf0;
   logic [15:0] sum0;

   // 8-bit, 1-bit chunks
   logic        start1 = 0, sub1 = 0, cin1 = 0;
   logic [7:0]  a1 = 0, b1 = 0;
   logic        busy1, done1, cout1, ovf1;
   logic [7:0]  sum1;

   // 8-bit, single chunk
   logic        start2 = 0, sub2 = 0, cin2 = 0;
   logic [7:0]  a2 = 0, b2 = 0;
   logic        busy2, done2, cout2, ovf2;
   logic [7:0]  sum2;

   multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0),
      .a(a0), .b(b0), .cin(cin0), .busy(busy0), .done(done0),
      .sum(sum0), .cout(cout0), .ovf(ovf0));

   multicycle_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
      .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
      .sum(sum1), .cout(cout1), .ovf(ovf1));

   multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2),
      .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2),
      .sum(sum2), .cout(cout2), .ovf(ovf2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one request into dut0 and let the accepting edge pass
   task automatic issue0(input logic s, input logic [15:0] x,
                         input logic [15:0] y, input logic c);
      start0 = 1; sub0 = s; a0 = x; b0 = y; cin0 = c;
      step();
      start0 = 0;
   endtask

   // cycles from acceptance to done, and busy cycles seen; 99 on timeout
   task automatic wait_done0(output int lat, output int bcnt);
      lat = 0;
      bcnt = 0;
      while (!done0 && lat < 40) begin
         if (busy0) bcnt++;
         step();
         lat++;
      end
      if (!done0) lat = 99;
   endtask

   task automatic test_reset();
      rst_n = 0;
      start0 = 1; a0 = 16'h1111; b0 = 16'h2222;
      start1 = 1; start2 = 1;
      step();
      step();
      n_checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl0: busy=%b done=%b want 0 0", busy0, done0);
      end
      n_checks++;
      if ({sum0, cout0, ovf0} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_out0: sum=%h cout=%b ovf=%b want 0", sum0, cout0, ovf0);
      end
      n_checks++;
      if ({busy1, done1, sum1, busy2, done2, sum2} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_out12: b1=%b d1=%b s1=%h b2=%b d2=%b s2=%h want 0",
                  busy1, done1, sum1, busy2, done2, sum2);
      end
      start0 = 0; start1 = 0; start2 = 0;
      rst_n = 1;
      step();
      n_checks++;
      if (busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored: busy=%b want 0", busy0);
      end
   endtask

   task automatic test_carry_wrap();
      int lat, bcnt;
      issue0(1'b0, 16'hFFFF, 16'h0001, 1'b0);
      wait_done0(lat, bcnt);
      n_checks++;
      if (lat !== 4 || bcnt !== 4) begin
         n_fail++;
         $display("FAIL wrap_latency: lat=%0d busy=%0d want 4 4", lat, bcnt);
      end
      n_checks++;
      if (sum0 !== 16'h0000 || cout0 !== 1'b1 || ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_result: sum=%h c=%b v=%b want 0000 1 0", sum0, cout0, ovf0);
      end
      step();
      n_checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_done_pulse: done=%b busy=%b want 0 0", done0, busy0);
      end
   endtask

   task automatic test_overflow_sub();
      int lat, bcnt;
      issue0(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      wait_done0(lat, bcnt);
      n_checks++;
      if (lat !== 4 || sum0 !== 16'h8000 || cout0 !== 1'b0 || ovf0 !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_add: lat=%0d sum=%h c=%b v=%b want 4 8000 0 1",
                  lat, sum0, cout0, ovf0);
      end
      step();
      // cin is ignored in subtract mode
      issue0(1'b1, 16'h0005, 16'h0007, 1'b1);
      wait_done0(lat, bcnt);
      n_checks++;
      if (lat !== 4 || sum0 !== 16'hFFFE || cout0 !== 1'b0 || ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_borrow: lat=%0d sum=%h c=%b v=%b want 4 fffe 0 0",
                  lat, sum0, cout0, ovf0);
      end
      step();
      issue0(1'b1, 16'h8000, 16'h0001, 1'b0);
      wait_done0(lat, bcnt);
      n_checks++;
      if (sum0 !== 16'h7FFF || cout0 !== 1'b1 || ovf0 !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_ovf: sum=%h c=%b v=%b want 7fff 1 1", sum0, cout0, ovf0);
      end
      step();
   endtask

   task automatic test_start_ignored();
      int dcnt;
      logic [15:0] dsum;
      issue0(1'b0, 16'h1000, 16'h0234, 1'b0);
      step();
      start0 = 1; sub0 = 1; a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1;
      step();
      n_checks++;
      if (sum0 !== 16'h7FFF || busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL run_hold: sum=%h busy=%b want 7fff 1", sum0, busy0);
      end
      step();
      start0 = 0;
      dcnt = 0;
      dsum = 16'h0;
      for (int i = 4; i <= 10; i++) begin
         step();
         if (done0) begin
            dcnt++;
            dsum = sum0;
         end
      end
      n_checks++;
      if (dcnt !== 1 || dsum !== 16'h1234) begin
         n_fail++;
         $display("FAIL start_in_run: dones=%0d sum=%h want 1 1234", dcnt, dsum);
      end
   endtask

   task automatic test_reset_abort();
      int dcnt, lat, bcnt;
      issue0(1'b0, 16'hAAAA, 16'h1111, 1'b0);
      step();
      rst_n = 0;
      step();
      rst_n = 1;
      n_checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || sum0 !== 16'h0) begin
         n_fail++;
         $display("FAIL abort_state: busy=%b done=%b sum=%h want 0 0 0",
                  busy0, done0, sum0);
      end
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done0 || sum0 != 16'h0) dcnt++;
      end
      n_checks++;
      if (dcnt !== 0) begin
         n_fail++;
         $display("FAIL abort_no_done: bad_cycles=%0d want 0", dcnt);
      end
      issue0(1'b0, 16'h1234, 16'h1111, 1'b1);
      wait_done0(lat, bcnt);
      n_checks++;
      if (lat !== 4 || sum0 !== 16'h2346 || cout0 !== 1'b0 || ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_next_op: lat=%0d sum=%h c=%b v=%b want 4 2346 0 0",
                  lat, sum0, cout0, ovf0);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [15:0] want;
      logic        wdone;
      start0 = 1; sub0 = 0; cin0 = 0;
      a0 = 16'h0010; b0 = 16'h0020;
      step();
      a0 = 16'h0100; b0 = 16'h0200;
      want = 16'h2346;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (i == 4) want = 16'h0030;
         if (i == 9) want = 16'h0300;
         if (i == 14) want = 16'h3000;
         if (i == 5) begin
            a0 = 16'h1000; b0 = 16'h2000;
         end
         wdone = (i == 4 || i == 9 || i == 14);
         n_checks++;
         if (done0 !== wdone || sum0 !== want || busy0 !== !wdone) begin
            n_fail++;
            $display("FAIL b2b_cyc%0d: done=%b busy=%b sum=%h want %b %b %h",
                     i, done0, busy0, sum0, wdone, !wdone, want);
         end
      end
      start0 = 0;
      step();
   endtask

   task automatic test_narrow();
      int lat;
      start1 = 1; a1 = 8'h80; b1 = 8'h80; sub1 = 0; cin1 = 0;
      step();
      start1 = 0;
      lat = 0;
      while (!done1 && lat < 40) begin
         step();
         lat++;
      end
      n_checks++;
      if (lat !== 8 || sum1 !== 8'h00 || cout1 !== 1'b1 || ovf1 !== 1'b1) begin
         n_fail++;
         $display("FAIL w8c1: lat=%0d sum=%h c=%b v=%b want 8 00 1 1",
                  lat, sum1, cout1, ovf1);
      end
      start2 = 1; a2 = 8'h7F; b2 = 8'h01; sub2 = 0; cin2 = 0;
      step();
      start2 = 0;
      n_checks++;
      if (busy2 !== 1'b1 || done2 !== 1'b0) begin
         n_fail++;
         $display("FAIL w8c8_run: busy=%b done=%b want 1 0", busy2, done2);
      end
      step();
      n_checks++;
      if (done2 !== 1'b1 || sum2 !== 8'h80 || cout2 !== 1'b0 || ovf2 !== 1'b1) begin
         n_fail++;
         $display("FAIL w8c8: done=%b sum=%h c=%b v=%b want 1 80 0 1",
                  done2, sum2, cout2, ovf2);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_carry_wrap();
      test_overflow_sub();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_narrow();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
